// File: rtl/mem_arb_pkg.sv
// Shared constants for the amber memory arbiters: owner encodings and the
// default fetch-starvation limit.
package mem_arb_pkg;

  localparam int HBIT_ARB_OWN       = 1;
  localparam int ARB_STARVE_MAX_DEF = 4;

  localparam logic [HBIT_ARB_OWN:0] ARB_OWN_NONE = 2'd0;
  localparam logic [HBIT_ARB_OWN:0] ARB_OWN_IF   = 2'd1;
  localparam logic [HBIT_ARB_OWN:0] ARB_OWN_MA   = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way winner select, shared with the DMA/debug port arbiter.
// AMBER_ARB_RR_EN selects round-robin; otherwise MA-priority with starvation override.
module mem_arb_pick (
  input  logic i_if_req,
  input  logic i_ma_req,
  input  logic i_starve_hit,
  input  logic i_last_ma,
  output logic o_if_win,
  output logic o_ma_win
);

  logic w_if_pref;

`ifdef AMBER_ARB_RR_EN
  logic w_unused_starve;
  assign w_if_pref       = i_last_ma;
  assign w_unused_starve = i_starve_hit;
`else
  logic w_unused_last;
  assign w_if_pref     = i_starve_hit;
  assign w_unused_last = i_last_ma;
`endif

  // On contention exactly one of the two terms below is true.
  assign o_if_win = i_if_req & (~i_ma_req | w_if_pref);
  assign o_ma_win = i_ma_req & (~i_if_req | ~w_if_pref);

endmodule

// File: rtl/mem_arb.sv
// IF/MA arbiter for the single-ported unified memory; routes 1-cycle read data
// back to its owner. Define AMBER_ARB_RR_EN for round-robin instead of MA-priority.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 24,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_if_req,
  input  logic [ADDR_W-1:0] iw_if_addr,
  output logic              ow_if_gnt,
  output logic              ow_if_rvalid,
  output logic [DATA_W-1:0] ow_if_rdata,
  input  logic              iw_ma_req,
  input  logic              iw_ma_we,
  input  logic [ADDR_W-1:0] iw_ma_addr,
  input  logic [DATA_W-1:0] iw_ma_wdata,
  output logic              ow_ma_gnt,
  output logic              ow_ma_rvalid,
  output logic [DATA_W-1:0] ow_ma_rdata,
  output logic              ow_mem_en,
  output logic              ow_mem_we,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [DATA_W-1:0] ow_mem_wdata,
  input  logic [DATA_W-1:0] iw_mem_rdata
);

  logic                  w_if_win;
  logic                  w_ma_win;
  logic                  w_if_gnt;
  logic                  w_ma_gnt;
  logic                  w_starve_hit;
  logic                  w_last_ma;
  logic [HBIT_ARB_OWN:0] r_owner;
  logic [HBIT_ARB_OWN:0] r_last;

  always_ff @(posedge iw_clk) begin
    assert (STARVE_MAX > 0);
  end

  assign w_last_ma = (r_last == ARB_OWN_MA);

  mem_arb_pick u_pick (
    .i_if_req     (iw_if_req),
    .i_ma_req     (iw_ma_req),
    .i_starve_hit (w_starve_hit),
    .i_last_ma    (w_last_ma),
    .o_if_win     (w_if_win),
    .o_ma_win     (w_ma_win)
  );

  // Reset gates the grants so no command reaches memory while held in reset.
  assign w_if_gnt = w_if_win & iw_rst;
  assign w_ma_gnt = w_ma_win & iw_rst;

`ifdef AMBER_ARB_RR_EN
  assign w_starve_hit = 1'b0;
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_starve <= '0;
    end else if (!iw_if_req || w_if_gnt) begin
      r_starve <= '0;
    end else if (r_starve != STARVE_LIM) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_starve_hit = (r_starve == STARVE_LIM);
`endif

  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_owner <= ARB_OWN_NONE;
      r_last  <= ARB_OWN_MA;
    end else begin
      if (w_if_gnt) begin
        r_owner <= ARB_OWN_IF;
      end else if (w_ma_gnt && !iw_ma_we) begin
        r_owner <= ARB_OWN_MA;
      end else begin
        r_owner <= ARB_OWN_NONE;
      end
      if (w_if_gnt) begin
        r_last <= ARB_OWN_IF;
      end else if (w_ma_gnt) begin
        r_last <= ARB_OWN_MA;
      end
    end
  end

  assign ow_if_gnt    = w_if_gnt;
  assign ow_ma_gnt    = w_ma_gnt;
  assign ow_mem_en    = w_if_gnt | w_ma_gnt;
  assign ow_mem_we    = w_ma_gnt & iw_ma_we;
  assign ow_mem_addr  = w_if_gnt ? iw_if_addr : (w_ma_gnt ? iw_ma_addr : '0);
  assign ow_mem_wdata = w_ma_gnt ? iw_ma_wdata : '0;

  assign ow_if_rvalid = (r_owner == ARB_OWN_IF);
  assign ow_ma_rvalid = (r_owner == ARB_OWN_MA);
  assign ow_if_rdata  = ow_if_rvalid ? iw_mem_rdata : '0;
  assign ow_ma_rdata  = ow_ma_rvalid ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural memory and a read-result scoreboard.
module tb_mem_arb;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;

`ifdef AMBER_ARB_RR_EN
  localparam bit [0:9] CONT_IF  = 10'b1010101010;
  localparam bit [0:8] DROP_IF  = 9'b101010101;
`else
  localparam bit [0:9] CONT_IF  = 10'b0000100001;
  localparam bit [0:8] DROP_IF  = 9'b000000001;
`endif
  localparam bit [0:8] DROP_REQ = 9'b111011111;

  typedef struct {
    logic              ifValid;
    logic [DATA_W-1:0] ifData;
    logic              maValid;
    logic [DATA_W-1:0] maData;
  } rdExp_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic              ifReqIn;
  logic [ADDR_W-1:0] ifAddrIn;
  logic              ifGnt;
  logic              ifRvalid;
  logic [DATA_W-1:0] ifRdata;
  logic              maReqIn;
  logic              maWeIn;
  logic [ADDR_W-1:0] maAddrIn;
  logic [DATA_W-1:0] maWdataIn;
  logic              maGnt;
  logic              maRvalid;
  logic [DATA_W-1:0] maRdata;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;

  logic [DATA_W-1:0] memStore [int];
  rdExp_t            sb [$];
  int                testsRun    = 0;
  int                testsFailed = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .iw_clk       (clk),
    .iw_rst       (rstN),
    .iw_if_req    (ifReqIn),
    .iw_if_addr   (ifAddrIn),
    .ow_if_gnt    (ifGnt),
    .ow_if_rvalid (ifRvalid),
    .ow_if_rdata  (ifRdata),
    .iw_ma_req    (maReqIn),
    .iw_ma_we     (maWeIn),
    .iw_ma_addr   (maAddrIn),
    .iw_ma_wdata  (maWdataIn),
    .ow_ma_gnt    (maGnt),
    .ow_ma_rvalid (maRvalid),
    .ow_ma_rdata  (maRdata),
    .ow_mem_en    (memEn),
    .ow_mem_we    (memWe),
    .ow_mem_addr  (memAddr),
    .ow_mem_wdata (memWdata),
    .iw_mem_rdata (memRdata)
  );

  // Unwritten locations read back a fixed pattern; 0x005 holds a known instruction word.
  function automatic logic [DATA_W-1:0] memInitWord(input logic [ADDR_W-1:0] a);
    if (a == 12'h005) return 24'h721003;
    return {a, ~a};
  endfunction

  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) begin
        memStore[int'(memAddr)] = memWdata;
      end else begin
        memRdata <= memStore.exists(int'(memAddr)) ? memStore[int'(memAddr)] : memInitWord(memAddr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    ifReqIn   = 1'b0;
    ifAddrIn  = '0;
    maReqIn   = 1'b0;
    maWeIn    = 1'b0;
    maAddrIn  = '0;
    maWdataIn = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    idleInputs();
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // One cycle: drive at the falling edge, check the combinational command, then
  // check the registered read result one rising edge later via the scoreboard.
  task automatic applyStimulus(input string tag, input logic ifReq, input logic [ADDR_W-1:0] ifAddr,
                               input logic maReq, input logic maWe, input logic [ADDR_W-1:0] maAddr,
                               input logic [DATA_W-1:0] maWdata, input logic expIfGnt,
                               input logic expMaGnt, input logic [DATA_W-1:0] expRdata);
    rdExp_t e;
    rdExp_t got;
    @(negedge clk);
    ifReqIn   = ifReq;
    ifAddrIn  = ifAddr;
    maReqIn   = maReq;
    maWeIn    = maWe;
    maAddrIn  = maAddr;
    maWdataIn = maWdata;
    #2;
    checkOutput({tag, " if_gnt"}, 32'(ifGnt), 32'(expIfGnt));
    checkOutput({tag, " ma_gnt"}, 32'(maGnt), 32'(expMaGnt));
    checkOutput({tag, " both_gnt"}, 32'(ifGnt & maGnt), 32'(0));
    checkOutput({tag, " mem_en"}, 32'(memEn), 32'(expIfGnt | expMaGnt));
    checkOutput({tag, " mem_we"}, 32'(memWe), 32'(expMaGnt & maWe));
    checkOutput({tag, " mem_addr"}, 32'(memAddr),
                32'(expIfGnt ? ifAddr : (expMaGnt ? maAddr : 12'h000)));
    if (expMaGnt && maWe) begin
      checkOutput({tag, " mem_wdata"}, 32'(memWdata), 32'(maWdata));
    end else if (!expIfGnt && !expMaGnt) begin
      checkOutput({tag, " mem_wdata"}, 32'(memWdata), 32'(0));
    end
    e.ifValid = expIfGnt;
    e.ifData  = expIfGnt ? expRdata : '0;
    e.maValid = expMaGnt && !maWe;
    e.maData  = (expMaGnt && !maWe) ? expRdata : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'(1));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checkOutput({tag, " if_rvalid"}, 32'(ifRvalid), 32'(got.ifValid));
      checkOutput({tag, " if_rdata"}, 32'(ifRdata), 32'(got.ifData));
      checkOutput({tag, " ma_rvalid"}, 32'(maRvalid), 32'(got.maValid));
      checkOutput({tag, " ma_rdata"}, 32'(maRdata), 32'(got.maData));
    end
  endtask

  initial begin
    idleInputs();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset if_rvalid", 32'(ifRvalid), 32'(0));
    checkOutput("reset ma_rvalid", 32'(maRvalid), 32'(0));
    checkOutput("reset if_rdata", 32'(ifRdata), 32'(0));
    checkOutput("reset ma_rdata", 32'(maRdata), 32'(0));
    checkOutput("reset mem_en", 32'(memEn), 32'(0));
    @(negedge clk);
    rstN = 1'b1;

    // IF-only read of the instruction word at 0x005.
    applyStimulus("if_read", 1'b1, 12'h005, 1'b0, 1'b0, 12'h000, 24'h0, 1'b1, 1'b0, 24'h721003);

    // Asserting reset while read data is valid must drop rvalid/rdata at once.
    rstN = 1'b0;
    #1;
    checkOutput("rst_async if_rvalid", 32'(ifRvalid), 32'(0));
    checkOutput("rst_async if_rdata", 32'(ifRdata), 32'(0));
    checkOutput("rst_async if_gnt", 32'(ifGnt), 32'(0));
    @(negedge clk);
    idleInputs();
    rstN = 1'b1;

    applyStimulus("idle", 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 24'h0, 1'b0, 1'b0, 24'h0);
    applyStimulus("ma_write", 1'b0, 12'h000, 1'b1, 1'b1, 12'hFFF, 24'h00ABCD, 1'b0, 1'b1, 24'h0);
    applyStimulus("ma_read", 1'b0, 12'h000, 1'b1, 1'b0, 12'hFFF, 24'h0, 1'b0, 1'b1, 24'h00ABCD);

    // Continuous contention from a clean reset.
    resetDut();
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("contend%0d", i), 1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 24'h0,
                    CONT_IF[i], !CONT_IF[i],
                    CONT_IF[i] ? memInitWord(12'h010) : memInitWord(12'h020));
    end

    // IF drops its request after three denials, then requests again.
    resetDut();
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("drop%0d", i), DROP_REQ[i], 12'h011, 1'b1, 1'b0, 12'h021, 24'h0,
                    DROP_IF[i], !DROP_IF[i],
                    DROP_IF[i] ? memInitWord(12'h011) : memInitWord(12'h021));
    end

    // A granted MA read is lost when reset asserts before the capturing edge.
    @(negedge clk);
    idleInputs();
    maReqIn  = 1'b1;
    maAddrIn = 12'h030;
    #2;
    checkOutput("rstdrop ma_gnt_pre", 32'(maGnt), 32'(1));
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("rstdrop ma_gnt_rst", 32'(maGnt), 32'(0));
    checkOutput("rstdrop mem_en_rst", 32'(memEn), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("rstdrop ma_rvalid", 32'(maRvalid), 32'(0));
    checkOutput("rstdrop ma_rdata", 32'(maRdata), 32'(0));
    @(negedge clk);
    idleInputs();
    rstN = 1'b1;
    #2;
    checkOutput("post_rst mem_en", 32'(memEn), 32'(0));
    checkOutput("post_rst gnts", 32'({ifGnt, maGnt}), 32'(0));
    checkOutput("post_rst mem_addr", 32'(memAddr), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("post_rst rvalids", 32'({ifRvalid, maRvalid}), 32'(0));
    checkOutput("post_rst rdata", 32'(ifRdata | maRdata), 32'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
